fft_reorder_tx: RTL and testbench

FFT_REORDER_TX -- requirements
Module: fft_reorder_tx

---
 rtl/fft_reorder_tx.sv | 120 ++++++++++++
 tb/tb_fft_reorder_tx.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_reorder_tx.sv
// Bit-reversed to natural-order FFT reorder buffer, two N-entry ping-pong banks; optional divide-by-N via FFT_REORDER_SCALE_EN.
// Latency: a frame is presented the cycle after its N-th input is accepted; one sample per cycle in steady state.
// Backpressure: in_ready drops only while both banks hold complete frames; outputs hold steady while out_valid && !out_ready.
module fft_reorder_tx #(
    parameter int LOG2N = 4,
    parameter int DW    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_re,
    input  logic [DW-1:0]    in_im,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_re,
    output logic [DW-1:0]    out_im,
    output logic [LOG2N-1:0] out_index,
    output logic             out_last
);

    localparam int N = 1 << LOG2N;

    logic [DW-1:0]    bank_re [2][N];
    logic [DW-1:0]    bank_im [2][N];
    logic [LOG2N-1:0] wr_cnt;
    logic [LOG2N-1:0] rd_cnt;
    logic [LOG2N-1:0] wr_addr;
    logic             wr_bank;
    logic             rd_bank;
    logic [1:0]       full;
    logic [1:0]       full_nxt;
    logic             wr_fire;
    logic             rd_fire;
    logic             wr_last;
    logic             rd_last;
    logic [DW-1:0]    rd_re;
    logic [DW-1:0]    rd_im;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = a[LOG2N-1-i];
        end
        return r;
    endfunction

    assign in_ready  = ~full[wr_bank];
    assign out_valid = full[rd_bank];
    assign wr_fire   = in_valid & in_ready;
    assign rd_fire   = out_valid & out_ready;
    assign wr_last   = &wr_cnt;
    assign rd_last   = &rd_cnt;
    assign wr_addr   = bitrev(wr_cnt);

    // Write and read always target different banks, so a same-cycle set and clear never collide.
    always_comb begin
        full_nxt = full;
        if (wr_fire && wr_last) begin
            full_nxt[wr_bank] = 1'b1;
        end
        if (rd_fire && rd_last) begin
            full_nxt[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            full    <= '0;
        end else begin
            full <= full_nxt;
            if (wr_fire) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_last) begin
                    wr_bank <= ~wr_bank;
                end
            end
            if (rd_fire) begin
                rd_cnt <= rd_cnt + 1'b1;
                if (rd_last) begin
                    rd_bank <= ~rd_bank;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < N; i++) begin
                    bank_re[b][i] <= '0;
                    bank_im[b][i] <= '0;
                end
            end
        end else if (wr_fire) begin
            bank_re[wr_bank][wr_addr] <= in_re;
            bank_im[wr_bank][wr_addr] <= in_im;
        end
    end

    assign rd_re     = bank_re[rd_bank][rd_cnt];
    assign rd_im     = bank_im[rd_bank][rd_cnt];
    assign out_index = rd_cnt;
    assign out_last  = out_valid & rd_last;

`ifdef FFT_REORDER_SCALE_EN
    // Arithmetic shift floors toward minus infinity, i.e. divide by N.
    assign out_re = $signed(rd_re) >>> LOG2N;
    assign out_im = $signed(rd_im) >>> LOG2N;
`else
    assign out_re = rd_re;
    assign out_im = rd_im;
`endif

endmodule

// File: tb/tb_fft_reorder_tx.sv
// Bench for fft_reorder_tx: random and directed traffic checked against a frame-level reorder model.
module tb_fft_reorder_tx;

    localparam int LOG2N = 4;
    localparam int DW    = 16;
    localparam int N     = 16;
`ifdef FFT_REORDER_SCALE_EN
    localparam int SC_RE = -1;
    localparam int SC_IM = 1;
`else
    localparam int SC_RE = -16;
    localparam int SC_IM = 17;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [DW-1:0]    in_re = '0;
    logic [DW-1:0]    in_im = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [DW-1:0]    out_re;
    logic [DW-1:0]    out_im;
    logic [LOG2N-1:0] out_index;
    logic             out_last;

    always #5 clk = ~clk;

    fft_reorder_tx #(.LOG2N(LOG2N), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
        .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
        .out_index(out_index), .out_last(out_last)
    );

    typedef struct { int re; int im; } samp_t;
    typedef struct { int idx; logic [DW-1:0] re; logic [DW-1:0] im; } outexp_t;

    samp_t   src_q[$];
    samp_t   cur_frame[$];
    outexp_t exp_q[$];
    bit      ready_pat[$];
    int      out_cyc[$];
    int      errors = 0;
    int      checks = 0;
    int      cyc = 0;
    int      n_acc = 0;
    int      vprob = 100;
    int      rprob = 100;
    int      first_acc_cyc = -1;
    int      first_vld_cyc = -1;
    bit      spot_en = 0;
    bit          spot_has [N];
    logic [DW-1:0] spot_re [N];
    logic [DW-1:0] spot_im [N];

    function automatic int bitrev(input int j);
        int r = 0;
        int x = j;
        for (int b = 0; b < LOG2N; b++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] scl(input int v);
`ifdef FFT_REORDER_SCALE_EN
        int q = v / N;
        if ((v % N) != 0 && v < 0) q = q - 1;
        return DW'(q);
`else
        return DW'(v);
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive();
        samp_t s;
        if (src_q.size() > 0 && int'($urandom_range(0, 99)) < vprob) begin
            s = src_q[0];
            in_valid = 1'b1;
            in_re = DW'(s.re);
            in_im = DW'(s.im);
        end else begin
            in_valid = 1'b0;
            in_re = DW'($urandom);
            in_im = DW'($urandom);
        end
        if (ready_pat.size() > 0) out_ready = ready_pat.pop_front();
        else out_ready = (int'($urandom_range(0, 99)) < rprob);
    endtask

    task automatic tick();
        bit      acc_in;
        bit      acc_out;
        outexp_t e;
        samp_t   s;
        @(negedge clk);
        cyc++;
        chk("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(((exp_q.size() + N - 1) / N) < 2));
        if (out_valid && exp_q.size() > 0) begin
            e = exp_q[0];
            chk("out_index", 64'(out_index), 64'(e.idx));
            chk("out_re", 64'(out_re), 64'(e.re));
            chk("out_im", 64'(out_im), 64'(e.im));
            chk("out_last", 64'(out_last), 64'(e.idx == N - 1));
            if (spot_en && spot_has[e.idx]) begin
                chk("spot_re", 64'(out_re), 64'(spot_re[e.idx]));
                chk("spot_im", 64'(out_im), 64'(spot_im[e.idx]));
            end
        end
        acc_in  = in_valid && in_ready;
        acc_out = out_valid && out_ready;
        if (acc_in) begin
            n_acc++;
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
        end
        if (out_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
        if (acc_out) out_cyc.push_back(cyc);
        @(posedge clk);
        #1;
        if (acc_out && exp_q.size() > 0) void'(exp_q.pop_front());
        if (acc_in && src_q.size() > 0) begin
            s = src_q.pop_front();
            cur_frame.push_back(s);
            if (cur_frame.size() == N) begin
                for (int j = 0; j < N; j++) begin
                    e.idx = j;
                    e.re  = scl(cur_frame[bitrev(j)].re);
                    e.im  = scl(cur_frame[bitrev(j)].im);
                    exp_q.push_back(e);
                end
                cur_frame.delete();
            end
        end
        drive();
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_index", 64'(out_index), 64'(0));
        chk("rst_out_re", 64'(out_re), 64'(0));
        chk("rst_out_im", 64'(out_im), 64'(0));
        chk("rst_out_last", 64'(out_last), 64'(0));
        src_q.delete();
        cur_frame.delete();
        exp_q.delete();
        ready_pat.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_idle(input int budget);
        int b = budget;
        while ((src_q.size() > 0 || exp_q.size() > 0) && b > 0) begin
            tick();
            b--;
        end
        chk("drain_done", 64'(src_q.size() + exp_q.size()), 64'(0));
    endtask

    function automatic samp_t rnd_samp();
        samp_t s;
        s.re = int'($urandom_range(0, 65535)) - 32768;
        s.im = int'($urandom_range(0, 65535)) - 32768;
        return s;
    endfunction

    initial begin
        int b;
        int span;
        samp_t s;
        for (int j = 0; j < N; j++) spot_has[j] = 0;
        do_reset();

        // Natural-order mapping: position k carries re=k, im=-k.
        for (int k = 0; k < N; k++) begin
            s.re = k;
            s.im = -k;
            src_q.push_back(s);
        end
        spot_has[1] = 1;  spot_re[1]  = scl(8);  spot_im[1]  = scl(-8);
        spot_has[2] = 1;  spot_re[2]  = scl(4);  spot_im[2]  = scl(-4);
        spot_has[15] = 1; spot_re[15] = scl(15); spot_im[15] = scl(-15);
        spot_en = 1;
        vprob = 100; rprob = 100;
        drive();
        run_idle(200);
        spot_en = 0;
        for (int j = 0; j < N; j++) spot_has[j] = 0;

        // Random valid/ready traffic over several frames.
        for (int i = 0; i < 6 * N; i++) src_q.push_back(rnd_samp());
        vprob = 70; rprob = 60;
        drive();
        run_idle(3000);

        // Backpressure: downstream stalled, 33rd input must be held.
        for (int i = 0; i < 3 * N; i++) src_q.push_back(rnd_samp());
        vprob = 100; rprob = 0; n_acc = 0;
        drive();
        b = 0;
        while (n_acc < 32 && b < 200) begin
            tick();
            b++;
        end
        repeat (3) tick();
        chk("bp_accepted", 64'(n_acc), 64'(32));
        chk("bp_in_ready", 64'(in_ready), 64'(0));
        chk("bp_out_valid", 64'(out_valid), 64'(1));
        chk("bp_out_index", 64'(out_index), 64'(0));
        rprob = 100;
        run_idle(500);

        // Output stall 1,0,0,1 mid-frame.
        for (int i = 0; i < N; i++) src_q.push_back(rnd_samp());
        vprob = 100; rprob = 100;
        drive();
        repeat (20) tick();
        ready_pat.push_back(1);
        ready_pat.push_back(0);
        ready_pat.push_back(0);
        ready_pat.push_back(1);
        run_idle(200);

        // Reset after 5 accepted inputs, then a clean frame.
        for (int i = 0; i < N; i++) src_q.push_back(rnd_samp());
        n_acc = 0;
        drive();
        b = 0;
        while (n_acc < 5 && b < 100) begin
            tick();
            b++;
        end
        chk("mid_reset_acc", 64'(n_acc), 64'(5));
        do_reset();
        for (int i = 0; i < N; i++) src_q.push_back(rnd_samp());
        vprob = 100; rprob = 100;
        drive();
        run_idle(200);

        // Four back-to-back frames with out_ready held high.
        for (int i = 0; i < 4 * N; i++) src_q.push_back(rnd_samp());
        first_acc_cyc = -1;
        first_vld_cyc = -1;
        out_cyc.delete();
        vprob = 100; rprob = 100;
        drive();
        run_idle(300);
        span = (out_cyc.size() > 0) ? (out_cyc[out_cyc.size() - 1] - out_cyc[0]) : -1;
        chk("stream_latency", 64'(first_vld_cyc - first_acc_cyc), 64'(16));
        chk("stream_count", 64'(out_cyc.size()), 64'(64));
        chk("stream_span", 64'(span), 64'(63));

        // Scaling: re=-16, im=17 everywhere.
        for (int k = 0; k < N; k++) begin
            s.re = -16;
            s.im = 17;
            src_q.push_back(s);
        end
        for (int j = 0; j < N; j++) begin
            spot_has[j] = 1;
            spot_re[j] = DW'(SC_RE);
            spot_im[j] = DW'(SC_IM);
        end
        spot_en = 1;
        drive();
        run_idle(200);
        spot_en = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
